ethercat_sm_mailbox: RTL

Single sync-manager mailbox responder. Sits at the physical end of the FMMU bus: it receives the `bus_rd`/`bus_wr` byte accesses that the FMMU issues for EtherCAT datagrams and returns `bus_data_in`/`bus_match`. On its other side it serves the local PDI. It owns a dual-port process RAM and enforces one-buffer (mailbox) handover on a configurable address window.

---
 rtl/ethercat_sm_mailbox.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ethercat_sm_mailbox.sv
// ethercat_sm_mailbox
// -------------------
// Single sync-manager mailbox responder at the physical end of the FMMU bus.
// Owns a dual-port byte RAM of 2^MEM_AW bytes at physical 0x0000. The ECAT
// side and the PDI side each get one access per cycle. Accesses inside the
// configured window follow one-buffer (mailbox) handover between a writer side
// and a reader side. Accesses outside the window are plain RAM accesses.
//
// Ports
//   rxc, RSTN                       clock; synchronous active-high reset
//   bus_address/bus_data_out        ECAT byte address / write data
//   bus_rd/bus_wr                   ECAT strobes (rd+wr together = write)
//   bus_data_in/bus_match           ECAT read data / accepted, registered
//   pdi_address/pdi_wdata           PDI byte address / write data
//   pdi_rd/pdi_wr                   PDI strobes (rd+wr together = write)
//   pdi_rdata/pdi_ack               PDI read data / accepted, registered
//   sm_start/sm_len/sm_enable       window base, length (0 = off), enable
//   sm_dir                          0: ECAT writes, PDI reads; 1: reversed
//   sm_state                        0 EMPTY, 1 WRITING, 2 FULL, 3 READING
//   irq_write/irq_read              one-cycle pulses on becoming FULL / EMPTY
module ethercat_sm_mailbox #(
    parameter int MEM_AW = 10
) (
    input  logic        rxc,
    input  logic        RSTN,
    input  logic [15:0] bus_address,
    input  logic [7:0]  bus_data_out,
    input  logic        bus_rd,
    input  logic        bus_wr,
    output logic [7:0]  bus_data_in,
    output logic        bus_match,
    input  logic [15:0] pdi_address,
    input  logic [7:0]  pdi_wdata,
    input  logic        pdi_rd,
    input  logic        pdi_wr,
    output logic [7:0]  pdi_rdata,
    output logic        pdi_ack,
    input  logic [15:0] sm_start,
    input  logic [15:0] sm_len,
    input  logic        sm_enable,
    input  logic        sm_dir,
    output logic [1:0]  sm_state,
    output logic        irq_write,
    output logic        irq_read
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_WRITING = 2'd1,
        ST_FULL    = 2'd2,
        ST_READING = 2'd3
    } sm_state_t;

    sm_state_t state;

    logic [7:0] mem [0:(2**MEM_AW)-1];

    // Window decode in 17 bits so start+len never wraps past 0xFFFF.
    logic        win_on;
    logic [16:0] len_x;
    logic [16:0] ram_top;
    assign win_on  = sm_enable && (sm_len != 16'd0);
    assign len_x   = {1'b0, sm_len};
    assign ram_top = 17'd1 << MEM_AW;

    logic [16:0] e_off, p_off;
    logic        e_hit, p_hit, e_last, p_last, e_in_ram, p_in_ram;
    assign e_off    = {1'b0, bus_address} - {1'b0, sm_start};
    assign p_off    = {1'b0, pdi_address} - {1'b0, sm_start};
    assign e_hit    = win_on && (bus_address >= sm_start) && (e_off < len_x);
    assign p_hit    = win_on && (pdi_address >= sm_start) && (p_off < len_x);
    assign e_last   = (e_off == len_x - 17'd1);
    assign p_last   = (p_off == len_x - 17'd1);
    assign e_in_ram = {1'b0, bus_address} < ram_top;
    assign p_in_ram = {1'b0, pdi_address} < ram_top;

    // A simultaneous rd+wr on one side is treated as a write only.
    logic e_wr, e_rd, p_wr, p_rd;
    assign e_wr = bus_wr;
    assign e_rd = bus_rd && !bus_wr;
    assign p_wr = pdi_wr;
    assign p_rd = pdi_rd && !pdi_wr;

    logic ecat_writer, can_write, can_read;
    assign ecat_writer = !sm_dir;
    assign can_write   = (state == ST_EMPTY) || (state == ST_WRITING);
    assign can_read    = (state == ST_FULL)  || (state == ST_READING);

    // Both sides judge legality against the pre-edge state. Because the
    // writable and readable states are disjoint, a reader access in the same
    // cycle as the final write is rejected automatically.
    logic e_ok, p_ok;
    assign e_ok = e_hit
        ? ((e_wr && ecat_writer && can_write) || (e_rd && !ecat_writer && can_read))
        : (e_in_ram && (e_wr || e_rd));
    assign p_ok = p_hit
        ? ((p_wr && !ecat_writer && can_write) || (p_rd && ecat_writer && can_read))
        : (p_in_ram && (p_wr || p_rd));

    logic wr_done, wr_last, rd_done, rd_last;
    assign wr_done = ecat_writer ? (e_ok && e_hit && e_wr) : (p_ok && p_hit && p_wr);
    assign wr_last = ecat_writer ? e_last : p_last;
    assign rd_done = ecat_writer ? (p_ok && p_hit && p_rd) : (e_ok && e_hit && e_rd);
    assign rd_last = ecat_writer ? p_last : e_last;

    logic [MEM_AW-1:0] e_idx, p_idx;
    assign e_idx = bus_address[MEM_AW-1:0];
    assign p_idx = pdi_address[MEM_AW-1:0];

    // NOTE: the RAM has no reset so it maps onto a true dual-port block RAM;
    // its contents are undefined until written.
    always_ff @(posedge rxc) begin
        if (!RSTN) begin
            if (e_ok && e_wr) mem[e_idx] <= bus_data_out;
            if (p_ok && p_wr) mem[p_idx] <= pdi_wdata;
        end
    end

    // NOTE: non-blocking assignments here mean the RAM reads below see the
    // pre-edge byte, which gives the old-data result on a same-address
    // write/read collision.
    always_ff @(posedge rxc) begin
        if (RSTN) begin
            state       <= ST_EMPTY;
            bus_data_in <= 8'h00;
            bus_match   <= 1'b0;
            pdi_rdata   <= 8'h00;
            pdi_ack     <= 1'b0;
            irq_write   <= 1'b0;
            irq_read    <= 1'b0;
        end else begin
            bus_match   <= e_ok;
            bus_data_in <= (e_ok && e_rd) ? mem[e_idx] : 8'h00;
            pdi_ack     <= p_ok;
            pdi_rdata   <= (p_ok && p_rd) ? mem[p_idx] : 8'h00;
            irq_write   <= 1'b0;
            irq_read    <= 1'b0;

            if (!sm_enable) begin
                state <= ST_EMPTY;
            end else if (wr_done) begin
                if (wr_last) begin
                    state     <= ST_FULL;
                    irq_write <= 1'b1;
                end else begin
                    state <= ST_WRITING;
                end
            end else if (rd_done) begin
                if (rd_last) begin
                    state    <= ST_EMPTY;
                    irq_read <= 1'b1;
                end else begin
                    state <= ST_READING;
                end
            end
        end
    end

    assign sm_state = state;

endmodule
